// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - 24-bit binary to BCD converter and 8-digit 7-segment scan controller
// Optional build macro SEG_ZERO_BLANK_EN: blank leading zero digits at commit.
module seg_scan_ctrl #(
  parameter int REFRESH_DIV = 12500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [23:0] value,
  output logic        busy,
  output logic [7:0]  an,
  output logic [4:0]  digit_holder
);

  localparam logic [4:0] CODE_BLANK = 5'b10000;
  localparam logic [4:0] CODE_DASH  = 5'b10001;
  localparam int         PW         = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [23:0]     shift_q;
  logic [31:0]     bcd_q;
  logic [31:0]     bcd_adj;
  logic [4:0]      iter_q;
  logic [7:0][4:0] disp_q;
  logic [7:0][4:0] commit_code;
  logic            accept;

  logic [PW-1:0]   presc_q;
  logic [2:0]      index_q;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          accept    = 1'b1;
          state_nxt = CONV;
        end
      end
      CONV: begin
        busy = 1'b1;
        if (iter_q == 5'd23) begin
          state_nxt = COMMIT;
        end
      end
      COMMIT: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Double-dabble correction: any nibble >= 5 gets +3 before the shift
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 8; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
`ifdef SEG_ZERO_BLANK_EN
    logic lead;
    lead        = 1'b1;
    commit_code = '0;
    for (int i = 7; i >= 0; i--) begin
      if (lead && (bcd_q[4*i +: 4] == 4'd0) && (i != 0)) begin
        commit_code[i] = CODE_BLANK;
      end else begin
        lead           = 1'b0;
        commit_code[i] = {1'b0, bcd_q[4*i +: 4]};
      end
    end
`else
    commit_code = '0;
    for (int i = 7; i >= 0; i--) begin
      commit_code[i] = {1'b0, bcd_q[4*i +: 4]};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      bcd_q   <= '0;
      iter_q  <= '0;
      disp_q  <= {8{CODE_DASH}};
    end else begin
      if (accept) begin
        shift_q <= value;
        bcd_q   <= '0;
        iter_q  <= '0;
      end else if (state == CONV) begin
        {bcd_q, shift_q} <= {bcd_adj, shift_q} << 1;
        iter_q           <= iter_q + 5'd1;
      end
      if (state == COMMIT) begin
        disp_q <= commit_code;
      end
    end
  end

  // Free-running scanner, never disturbed by conversions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      index_q <= '0;
    end else if (presc_q == PRESC_LAST) begin
      presc_q <= '0;
      index_q <= index_q + 3'd1;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an           <= 8'hFF;
      digit_holder <= CODE_BLANK;
    end else begin
      an           <= ~(8'b1 << index_q);
      digit_holder <= disp_q[index_q];
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - scoreboard bench for seg_scan_ctrl (REFRESH_DIV=4)
module tb_seg_scan_ctrl;

  localparam int DIV = 4;
`ifdef SEG_ZERO_BLANK_EN
  localparam bit ZB = 1'b1;
`else
  localparam bit ZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [23:0] value = '0;
  logic        busy;
  logic [7:0]  an;
  logic [4:0]  digit_holder;

  int total = 0;
  int bad = 0;

  logic [39:0] exp_q[$];
  logic [39:0] exp_disp;

  bit scan_valid = 1'b0;
  bit first_run = 1'b1;
  int prev_idx = 0;
  int run_len = 0;
  int cur_idx = -1;

  seg_scan_ctrl #(.REFRESH_DIV(DIV)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .load(load),
    .value(value),
    .busy(busy),
    .an(an),
    .digit_holder(digit_holder)
  );

  always #5 clk = ~clk;

  function automatic logic [39:0] model(int unsigned v);
    logic [39:0] r;
    int unsigned digs[8];
    bit lead;
    r = '0;
    lead = 1'b1;
    for (int i = 0; i < 8; i++) begin
      digs[i] = v % 10;
      v = v / 10;
    end
    for (int i = 7; i >= 0; i--) begin
      if (ZB && lead && digs[i] == 0 && i != 0) begin
        r[5*i +: 5] = 5'b10000;
      end else begin
        lead = 1'b0;
        r[5*i +: 5] = {1'b0, 4'(digs[i])};
      end
    end
    return r;
  endfunction

  // Advance one clock and watch the scan: one-hot low anode, +1 index steps, DIV-cycle slots
  task automatic tick();
    int idx;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      scan_valid = 1'b0;
      cur_idx = -1;
      return;
    end
    idx = -1;
    for (int i = 0; i < 8; i++) begin
      if (an == ~(8'b1 << i)) idx = i;
    end
    total++;
    if (idx < 0) begin
      bad++;
      $display("FAIL onehot: an=%h, required exactly one low bit", an);
      scan_valid = 1'b0;
    end else if (!scan_valid) begin
      scan_valid = 1'b1;
      first_run = 1'b1;
      prev_idx = idx;
      run_len = 1;
    end else if (idx == prev_idx) begin
      run_len++;
      if (run_len > DIV) begin
        bad++;
        $display("FAIL slot_len: index %0d held %0d cycles, required %0d", idx, run_len, DIV);
      end
    end else begin
      total++;
      if (idx != (prev_idx + 1) % 8 || (!first_run && run_len != DIV)) begin
        bad++;
        $display("FAIL index_step: %0d->%0d after %0d cycles, required %0d->%0d after %0d",
                 prev_idx, idx, run_len, prev_idx, (prev_idx + 1) % 8, DIV);
      end
      prev_idx = idx;
      run_len = 1;
      first_run = 1'b0;
    end
    cur_idx = idx;
  endtask

  task automatic do_load(input logic [23:0] v);
    value = v;
    load = 1'b1;
    exp_q.push_back(model(v));
    tick();
    load = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL accept_busy: value=%0d busy=%b, required 1", v, busy);
    end
  endtask

  // Run edges k+1..k+25; optionally pulse load at edge k+inj (must be dropped)
  task automatic wait_conv(input int inj, input logic [23:0] iv);
    for (int i = 1; i <= 25; i++) begin
      if (i == inj) begin
        value = iv;
        load = 1'b1;
      end
      tick();
      load = 1'b0;
      total++;
      if (busy !== (i < 25)) begin
        bad++;
        $display("FAIL busy_k%0d: busy=%b, required %b", i, busy, (i < 25));
      end
    end
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL scoreboard: commit with empty queue, required a pending value");
    end else begin
      exp_disp = exp_q.pop_front();
    end
  endtask

  task automatic check_display(input string name);
    for (int c = 0; c < 8 * DIV + 2; c++) begin
      tick();
      if (cur_idx >= 0) begin
        total++;
        if (digit_holder !== exp_disp[5*cur_idx +: 5]) begin
          bad++;
          $display("FAIL %s_digit%0d: digit_holder=%b, required %b",
                   name, cur_idx, digit_holder, exp_disp[5*cur_idx +: 5]);
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] exp_an;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (an !== 8'hFF || digit_holder !== 5'b10000 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: an=%h dh=%b busy=%b, required FF 10000 0", an, digit_holder, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 9 * DIV; c++) begin
      tick();
      exp_an = ~(8'b1 << (((c - 1) / DIV) % 8));
      total++;
      if (an !== exp_an || digit_holder !== 5'b10001 || busy !== 1'b0) begin
        bad++;
        $display("FAIL reset_scan_c%0d: an=%h dh=%b busy=%b, required %h 10001 0",
                 c, an, digit_holder, busy, exp_an);
      end
    end
    exp_disp = {8{5'b10001}};
    check_display("dash");
  endtask

  task automatic test_convert(input logic [23:0] v, input string name);
    do_load(v);
    wait_conv(0, '0);
    check_display(name);
  endtask

  task automatic test_ignored_load();
    do_load(24'd42);
    wait_conv(10, 24'd99);
    check_display("ignore42");
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL ignore_queue: %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    do_load(24'd5);
    wait_conv(0, '0);
    do_load(24'd99);
    wait_conv(0, '0);
    check_display("b2b99");
  endtask

  task automatic test_reset_mid_conv();
    do_load(24'd555);
    for (int i = 1; i <= 11; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || an !== 8'hFF || digit_holder !== 5'b10000) begin
      bad++;
      $display("FAIL midreset: busy=%b an=%h dh=%b, required 0 FF 10000", busy, an, digit_holder);
    end
    exp_q.delete();
    exp_disp = {8{5'b10001}};
    scan_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_display("midreset_dash");
    for (int i = 1; i <= 30; i++) begin
      tick();
      total++;
      if (busy !== 1'b0) begin
        bad++;
        $display("FAIL midreset_busy%0d: busy=%b, required 0", i, busy);
      end
    end
  endtask

  task automatic test_repeat_frame();
    for (int n = 0; n < 4; n++) begin
      do_load(24'd7);
      wait_conv(0, '0);
    end
    check_display("repeat7");
  endtask

  initial begin
    exp_disp = {8{5'b10001}};
    test_reset();
    test_convert(24'd1234, "v1234");
    test_convert(24'd16777215, "vmax");
    test_convert(24'd0, "vzero");
    test_convert(24'd10000000, "v1e7");
    test_ignored_load();
    test_back_to_back();
    test_reset_mid_conv();
    test_repeat_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexing controller for the board's 8-digit common-anode 7-segment display. It accepts a 24-bit binary score and converts it to BCD with a sequential double-dabble engine. It then scans the eight digits at a fixed refresh rate, driving the anode lines and the 5-bit digit code that the segment decoder turns into cathode patterns. It sits between the game score logic and the segment decoder.

## Interface
- REFRESH_DIV, 12500: clk cycles per digit slot. At 100 MHz this gives 8 kHz slots, or 1 kHz per digit. Legal values are ≥ 2.
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- load  input  1  request to display `value`. Sampled every cycle.
- value  input  24  unsigned binary number to display (0..16777215)
- busy  output  1  conversion in progress. `load` is ignored while high.
- an  output  8  anode enables, active low. Bit i is digit i, with digit 0 rightmost.
- digit_holder  output  5  digit code to the segment decoder: 0–9 = numerals, 5'b10000 = blank, 5'b10001 = dash

## Operation
- **FSM states**
  - IDLE: if `load && !busy`, capture `value` into the shift register, clear the 32-bit BCD accumulator, clear the iteration counter, and go to CONV.
  - CONV: one double-dabble iteration per cycle.
    - Every BCD nibble ≥ 5 gets +3.
    - Then {bcd, shift} shifts left by 1.
    - The counter increments. After the 24th iteration, go to COMMIT.
  - COMMIT: copy the 8 BCD nibbles into the display register and return to IDLE.
- `busy` is 1 in CONV and COMMIT, and 0 in IDLE.
- A `load` pulse asserted during CONV or COMMIT is dropped, not queued. `value` may change freely after the accept cycle.
- **Display register:** 8 × 5-bit codes. The reset value is all dash (5'b10001), so "--------" shows until the first commit.
- **Scanner**
  - The prescaler counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, the digit index advances 0→1→…→7→0.
  - The scanner runs continuously and independently of the FSM. A commit never resets the index or the prescaler.
- **Outputs (registered, updated every clk)**
  - `an` = ~(1 << index).
  - `digit_holder` = display[index].
  - Exactly one `an` bit is low at any time after the first post-reset clock.
- Conversion arithmetic is exact for all 24-bit inputs. The maximum value, 16777215, needs all 8 digits, so overflow cannot occur.

## Timing
- **Reset values:** `an` = 8'hFF, `digit_holder` = 5'b10000, `busy` = 0, FSM in IDLE, index = 0, prescaler = 0, display = all dash.
- **First post-reset edge:** `an` = 8'hFE and `digit_holder` = 5'b10001.
- **Conversion latency:**
  - Accept edge k: `busy` is 1 after edge k.
  - CONV occupies edges k+1..k+24.
  - COMMIT at edge k+25 updates the display register, and `busy` is 0 after k+25.
  - The new code appears on `digit_holder` from edge k+26 while the matching digit is selected.
- Back-to-back loads: the earliest next accept is edge k+26, when `load` is high in the cycle `busy` first reads 0.
- **Digit slot:** exactly REFRESH_DIV cycles. A full frame is 8·REFRESH_DIV cycles.
- **Reset mid-conversion:** all state returns to reset values immediately. The partial result is discarded and the display returns to all dash.

## Configuration
- `SEG_ZERO_BLANK_EN`
  - **Defined:** at COMMIT, leading zero nibbles are written as blank (5'b10000), scanning from digit 7 down. Digit 0 always shows its numeral, so value 0 shows a single "0".
  - **Undefined:** all 8 nibbles are written as numerals, including leading zeros.
  - Reset and dash behaviour is identical in both builds.

## Test plan
- Reset, run with REFRESH_DIV=4 → `busy`=0, and all eight slots show 5'b10001 with `an` cycling FE, FD, FB, …, 7F, FE in 4-cycle slots.
- Load 1234 at edge k → `busy` high k+1..k+25. Slots 3..0 then read 1, 2, 3, 4. Slots 7..4 read 5'b10000 with `SEG_ZERO_BLANK_EN`, and 0 without it.
- Load 16777215 → slots 7..0 read 1, 6, 7, 7, 7, 2, 1, 5. Load 0 → slot 0 reads 0, and slots 7..1 read blank with `SEG_ZERO_BLANK_EN`.
- Load 42, then pulse load with 99 at k+10 → 99 is ignored and the display shows 42. A load of 99 at k+26 is accepted.
- Assert rst_n=0 at k+12 during a conversion of 555 → `busy`=0 and `an`=FF immediately. After release, the display is all dash.
- Load 7 repeatedly across a frame boundary → the index sequence never skips or repeats, and no cycle shows two `an` bits low.
